// File: rtl/pipe_stage_skid_reg_if.sv
// rtl/pipe_stage_skid_reg_if.sv - valid/ready handshake bundle carrying a PC and an instruction word
interface pipe_stage_skid_reg_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
);
    logic               valid;
    logic               ready;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;

    // Producer side: offers pc/instr, observes ready.
    modport master (
        output valid,
        output pc,
        output instr,
        input  ready
    );

    // Consumer side: observes the offer, drives ready.
    modport slave (
        input  valid,
        input  pc,
        input  instr,
        output ready
    );
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - elastic pipeline stage register with optional skid entry and stall counter
module pipe_stage_skid_reg #(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter int                 DEPTH     = 2,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    pipe_stage_skid_reg_if.slave  up,
    pipe_stage_skid_reg_if.master dn,
    output logic [1:0]            occupancy,
    output logic [CNT_W-1:0]      stall_cnt
);

    // Only a plain register (1) or a register plus one skid entry (2) make sense here.
    if (DEPTH != 1 && DEPTH != 2) begin : g_depth_check
        $error("pipe_stage_skid_reg: DEPTH must be 1 or 2");
    end

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [PC_W-1:0]    head_pc;
    logic [INSTR_W-1:0] head_instr;
    logic [PC_W-1:0]    skid_pc;
    logic [INSTR_W-1:0] skid_instr;

    logic               in_ready;
    logic               out_valid;
    logic               push;
    logic               pop;

    logic               head_load_in;
    logic               head_load_skid;
    logic               skid_load;

    logic [CNT_W-1:0]   stall_q;
    logic               stall_event;

    assign out_valid = (state_q != ST_EMPTY);
    assign push      = up.valid & in_ready;
    assign pop       = out_valid & dn.ready;

    if (DEPTH == 1) begin : g_ready_comb
        // Single entry: a slot frees up in the same cycle the head is consumed.
        assign in_ready = ~out_valid | dn.ready;
    end else begin : g_ready_reg
        logic in_ready_q;

        // Ready is a flop of "next state is not TWO", so out_ready never reaches in_ready combinationally.
        always_ff @(posedge clk) begin
            if (rst) begin
                in_ready_q <= 1'b1;
            end else begin
                in_ready_q <= (state_d != ST_TWO);
            end
        end

        assign in_ready = in_ready_q;
    end

    // Occupancy state register; reset and flush both return the stage to EMPTY.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and entry-load decode; flush overrides so a same-cycle push is swallowed.
    always_comb begin
        state_d        = state_q;
        head_load_in   = 1'b0;
        head_load_skid = 1'b0;
        skid_load      = 1'b0;

        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d      = ST_ONE;
                    head_load_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    head_load_in = 1'b1;
                end else if (push) begin
                    // Only reachable with DEPTH=2; with DEPTH=1 in_ready is low here.
                    state_d   = ST_TWO;
                    skid_load = 1'b1;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_d        = ST_ONE;
                    head_load_skid = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        if (flush) begin
            state_d        = ST_EMPTY;
            head_load_in   = 1'b0;
            head_load_skid = 1'b0;
            skid_load      = 1'b0;
        end
    end

    // Head entry: loaded from the input or promoted from the skid entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_pc    <= '0;
            head_instr <= NOP_INSTR;
        end else if (head_load_in) begin
            head_pc    <= up.pc;
            head_instr <= up.instr;
        end else if (head_load_skid) begin
            head_pc    <= skid_pc;
            head_instr <= skid_instr;
        end
    end

    // Skid entry: catches the one push that lands while the head is blocked.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_pc    <= '0;
            skid_instr <= NOP_INSTR;
        end else if (skid_load) begin
            skid_pc    <= up.pc;
            skid_instr <= up.instr;
        end
    end

    assign stall_event = up.valid & ~in_ready;

    // Saturating count of cycles upstream was held off; survives flush, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (stall_event && !(&stall_q)) begin
            stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Occupancy mirrors the state encoding.
    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            ST_EMPTY: occupancy = 2'd0;
            ST_ONE:   occupancy = 2'd1;
            ST_TWO:   occupancy = 2'd2;
            default:  occupancy = 2'd0;
        endcase
    end

    assign up.ready  = in_ready;
    assign dn.valid  = out_valid;
    assign dn.pc     = out_valid ? head_pc : '0;
    assign dn.instr  = out_valid ? head_instr : NOP_INSTR;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb/tb_pipe_stage_skid_reg.sv - directed table-driven bench for pipe_stage_skid_reg
module tb_pipe_stage_skid_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] IA  = 32'h8c22_0000;
    localparam logic [31:0] IB  = 32'h8c23_0004;
    localparam logic [31:0] IC  = 32'h8c24_0008;
    localparam logic [31:0] ID  = 32'h1111_1111;
    localparam logic [31:0] IE  = 32'h2222_2222;
    localparam logic [31:0] IF  = 32'h3333_3333;
    localparam logic [31:0] IG  = 32'h4444_4444;
    localparam int NVEC = 18;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    logic [1:0]  d2_occ;
    logic [15:0] d2_stall;
    logic [1:0]  d1_occ;
    logic [15:0] d1_stall;
    logic [1:0]  sat_occ;
    logic [3:0]  sat_stall;

    int checks = 0;
    int errors = 0;

    pipe_stage_skid_reg_if #(.PC_W(32), .INSTR_W(32)) d2_up ();
    pipe_stage_skid_reg_if #(.PC_W(32), .INSTR_W(32)) d2_dn ();
    pipe_stage_skid_reg_if #(.PC_W(32), .INSTR_W(32)) d1_up ();
    pipe_stage_skid_reg_if #(.PC_W(32), .INSTR_W(32)) d1_dn ();
    pipe_stage_skid_reg_if #(.PC_W(32), .INSTR_W(32)) sat_up ();
    pipe_stage_skid_reg_if #(.PC_W(32), .INSTR_W(32)) sat_dn ();

    pipe_stage_skid_reg #(.PC_W(32), .INSTR_W(32), .DEPTH(2), .NOP_INSTR(NOP), .CNT_W(16)) u_d2 (
        .clk(clk), .rst(rst), .flush(flush), .up(d2_up), .dn(d2_dn),
        .occupancy(d2_occ), .stall_cnt(d2_stall)
    );

    pipe_stage_skid_reg #(.PC_W(32), .INSTR_W(32), .DEPTH(1), .NOP_INSTR(NOP), .CNT_W(16)) u_d1 (
        .clk(clk), .rst(rst), .flush(flush), .up(d1_up), .dn(d1_dn),
        .occupancy(d1_occ), .stall_cnt(d1_stall)
    );

    pipe_stage_skid_reg #(.PC_W(32), .INSTR_W(32), .DEPTH(2), .NOP_INSTR(NOP), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .flush(flush), .up(sat_up), .dn(sat_dn),
        .occupancy(sat_occ), .stall_cnt(sat_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic        e_ir;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [1:0]  e_occ;
        logic [15:0] e_stall;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // streaming
        vecs[0]  = '{1'b1, 32'h00, 32'h2001_0005, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00, 32'h2001_0005, 2'd1, 16'd0};
        vecs[1]  = '{1'b1, 32'h04, 32'h2002_0003, 1'b1, 1'b0, 1'b1, 1'b1, 32'h04, 32'h2002_0003, 2'd1, 16'd0};
        vecs[2]  = '{1'b1, 32'h08, 32'h0022_1820, 1'b1, 1'b0, 1'b1, 1'b1, 32'h08, 32'h0022_1820, 2'd1, 16'd0};
        vecs[3]  = '{1'b0, 32'h00, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'h00, NOP,          2'd0, 16'd0};
        // backpressure into skid, then drain
        vecs[4]  = '{1'b1, 32'h10, IA, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10, IA,  2'd1, 16'd0};
        vecs[5]  = '{1'b1, 32'h14, IB, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, IA,  2'd2, 16'd0};
        vecs[6]  = '{1'b1, 32'h18, IC, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, IA,  2'd2, 16'd1};
        vecs[7]  = '{1'b1, 32'h18, IC, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, IA,  2'd2, 16'd2};
        vecs[8]  = '{1'b1, 32'h18, IC, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, IA,  2'd2, 16'd3};
        vecs[9]  = '{1'b1, 32'h18, IC, 1'b1, 1'b0, 1'b1, 1'b1, 32'h14, IB,  2'd1, 16'd4};
        vecs[10] = '{1'b1, 32'h18, IC, 1'b1, 1'b0, 1'b1, 1'b1, 32'h18, IC,  2'd1, 16'd4};
        vecs[11] = '{1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00, NOP, 2'd0, 16'd4};
        // flush in TWO, then flush in ONE while a push completes
        vecs[12] = '{1'b1, 32'h20, ID, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20, ID,  2'd1, 16'd4};
        vecs[13] = '{1'b1, 32'h24, IE, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, ID,  2'd2, 16'd4};
        vecs[14] = '{1'b0, 32'h00, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00, NOP, 2'd0, 16'd4};
        vecs[15] = '{1'b1, 32'h28, IF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h28, IF,  2'd1, 16'd4};
        vecs[16] = '{1'b1, 32'h2c, IG, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00, NOP, 2'd0, 16'd4};
        vecs[17] = '{1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00, NOP, 2'd0, 16'd4};

        rst = 1'b1;
        flush = 1'b0;
        d2_up.valid = 1'b0;  d2_up.pc = '0;  d2_up.instr = '0;  d2_dn.ready = 1'b0;
        d1_up.valid = 1'b0;  d1_up.pc = '0;  d1_up.instr = '0;  d1_dn.ready = 1'b0;
        sat_up.valid = 1'b0; sat_up.pc = '0; sat_up.instr = '0; sat_dn.ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_out_valid", 64'(d2_dn.valid), 64'd0);
        check("rst_out_pc",    64'(d2_dn.pc),    64'd0);
        check("rst_out_instr", 64'(d2_dn.instr), 64'(NOP));
        check("rst_in_ready",  64'(d2_up.ready), 64'd1);
        check("rst_occ",       64'(d2_occ),      64'd0);
        check("rst_stall",     64'(d2_stall),    64'd0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            d2_up.valid = vecs[i].iv;
            d2_up.pc    = vecs[i].pc;
            d2_up.instr = vecs[i].instr;
            d2_dn.ready = vecs[i].ordy;
            flush       = vecs[i].fl;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_out_valid", i), 64'(d2_dn.valid), 64'(vecs[i].e_ov));
            check($sformatf("v%0d_in_ready", i),  64'(d2_up.ready), 64'(vecs[i].e_ir));
            check($sformatf("v%0d_out_pc", i),    64'(d2_dn.pc),    64'(vecs[i].e_pc));
            check($sformatf("v%0d_out_instr", i), 64'(d2_dn.instr), 64'(vecs[i].e_instr));
            check($sformatf("v%0d_occ", i),       64'(d2_occ),      64'(vecs[i].e_occ));
            check($sformatf("v%0d_stall", i),     64'(d2_stall),    64'(vecs[i].e_stall));
        end

        // Reset while holding two entries: both dropped, ready back immediately.
        @(negedge clk);
        flush = 1'b0;
        d2_up.valid = 1'b1; d2_up.pc = 32'h30; d2_up.instr = IA; d2_dn.ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        d2_up.pc = 32'h34; d2_up.instr = IB;
        @(posedge clk);
        #1;
        check("pre_rst_occ", 64'(d2_occ), 64'd2);
        @(negedge clk);
        rst = 1'b1;
        d2_up.valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_two_occ",      64'(d2_occ),      64'd0);
        check("rst_two_in_ready", 64'(d2_up.ready), 64'd1);
        check("rst_two_valid",    64'(d2_dn.valid), 64'd0);
        check("rst_two_stall",    64'(d2_stall),    64'd0);

        // DEPTH=1: combinational ready and full-rate head replacement.
        d1_up.valid = 1'b1; d1_up.pc = 32'h100; d1_up.instr = IA; d1_dn.ready = 1'b0;
        #1;
        check("d1_empty_ready", 64'(d1_up.ready), 64'd1);
        @(posedge clk);
        #1;
        check("d1_fill_valid", 64'(d1_dn.valid), 64'd1);
        check("d1_fill_pc",    64'(d1_dn.pc),    64'h100);
        check("d1_full_block", 64'(d1_up.ready), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            d1_dn.ready = 1'b1;
            d1_up.pc    = 32'h100 + 32'(4 * k);
            d1_up.instr = IC + 32'(k);
            #1;
            check($sformatf("d1_k%0d_ready_same_cycle", k), 64'(d1_up.ready), 64'd1);
            @(posedge clk);
            #1;
            check($sformatf("d1_k%0d_pc", k),    64'(d1_dn.pc),    64'(32'h100 + 32'(4 * k)));
            check($sformatf("d1_k%0d_instr", k), 64'(d1_dn.instr), 64'(IC + 32'(k)));
            check($sformatf("d1_k%0d_occ", k),   64'(d1_occ),      64'd1);
        end
        @(negedge clk);
        d1_up.valid = 1'b0;
        @(posedge clk);
        #1;
        check("d1_drain_valid", 64'(d1_dn.valid), 64'd0);
        check("d1_drain_instr", 64'(d1_dn.instr), 64'(NOP));
        check("d1_stall",       64'(d1_stall),    64'd0);

        // CNT_W=4 saturation: two pushes fill the stage, then 20 stalled edges.
        @(negedge clk);
        sat_up.valid = 1'b1; sat_up.pc = 32'h40; sat_up.instr = ID; sat_dn.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("sat_full_occ", 64'(sat_occ), 64'd2);
        for (int s = 1; s <= 20; s++) begin
            @(posedge clk);
            #1;
            check($sformatf("sat_s%0d", s), 64'(sat_stall), 64'((s > 15) ? 15 : s));
        end
        @(negedge clk);
        rst = 1'b1;
        sat_up.valid = 1'b0;
        @(posedge clk);
        #1;
        check("sat_rst_stall", 64'(sat_stall), 64'd0);
        check("sat_rst_occ",   64'(sat_occ),   64'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
